// File: rtl/hazard_pkg.sv
// Shared types for the LEGv8 pipeline hazard control: FSM states and register indices.
package hazard_pkg;

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} hz_state_t;

    // Register index type, also used by the forwarding unit.
    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = 5'd31;

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter with asynchronous active-low reset and synchronous clear.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard control: load-use bubbles, data-memory freeze with timeout,
// taken-branch flushes and saturating stall/flush counters.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             memwb_bubble,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    hz_state_t         state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              luh;
    logic              mst;
    logic              freeze;

    always_comb begin
        luh = ex_mem_read && (reg_idx_t'(ex_rd) != ZERO_REG) &&
              ((id_use_rn && (id_rn == ex_rd)) || (id_use_rm && (id_rm == ex_rd)));
        mst = mem_req && !mem_ack;
    end

    always_comb begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        ifid_flush   = 1'b0;
        idex_en      = 1'b0;
        idex_bubble  = 1'b0;
        exmem_en     = 1'b0;
        memwb_bubble = 1'b0;
        unique case (state)
            RUN:      freeze = mst;
            MEM_WAIT: freeze = !mem_ack;
            default:  freeze = 1'b1;
        endcase
        // Outputs are gated by the raw reset so they drop without waiting for a clock.
        if (!reset) begin
            pc_en = 1'b0;
        end else if (freeze) begin
            memwb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            idex_en     = 1'b1;
            idex_bubble = 1'b1;
            exmem_en    = 1'b1;
        end else if (luh) begin
            idex_en     = 1'b1;
            idex_bubble = 1'b1;
            exmem_en    = 1'b1;
        end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_error <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (mst) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack) begin
                        state <= RUN;
                    end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
                        state     <= ERROR;
                        mem_error <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: state <= ERROR;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clear (1'b0),
        .inc   (reset && !pc_en),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clear (1'b0),
        .inc   (ifid_flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: vector table for RUN decoding plus
// hand sequences for memory freeze, timeout, saturation and asynchronous reset.
module tb_hazard_stall_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, reset_to;
    logic [4:0] id_rn, id_rm, ex_rd;
    logic       id_use_rn, id_use_rm, ex_mem_read, ex_branch_taken, mem_req, mem_ack;

    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble, mem_error;
    logic [31:0] stall_count, flush_count;
    logic        pc_en_t, ifid_en_t, ifid_flush_t, idex_en_t, idex_bubble_t, exmem_en_t, memwb_bubble_t, mem_error_t;
    logic [2:0]  stall_count_t, flush_count_t;

    hazard_stall_unit dut (
        .clk(clk), .reset(reset),
        .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_bubble(idex_bubble), .exmem_en(exmem_en), .memwb_bubble(memwb_bubble),
        .mem_error(mem_error), .stall_count(stall_count), .flush_count(flush_count)
    );

    // Short timeout and 3-bit counters so timeout and saturation are reachable quickly.
    hazard_stall_unit #(.CNT_W(3), .MAX_WAIT(4)) dut_to (
        .clk(clk), .reset(reset_to),
        .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en_t), .ifid_en(ifid_en_t), .ifid_flush(ifid_flush_t), .idex_en(idex_en_t),
        .idex_bubble(idex_bubble_t), .exmem_en(exmem_en_t), .memwb_bubble(memwb_bubble_t),
        .mem_error(mem_error_t), .stall_count(stall_count_t), .flush_count(flush_count_t)
    );

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble}
    wire [6:0] outs   = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble};
    wire [6:0] outs_t = {pc_en_t, ifid_en_t, ifid_flush_t, idex_en_t, idex_bubble_t, exmem_en_t, memwb_bubble_t};

    localparam logic [6:0] O_NORM = 7'b1101010;
    localparam logic [6:0] O_LUH  = 7'b0001110;
    localparam logic [6:0] O_BR   = 7'b1111110;
    localparam logic [6:0] O_FRZ  = 7'b0000001;
    localparam logic [6:0] O_OFF  = 7'b0000000;

    typedef struct {
        logic [4:0] rn, rm;
        logic       urn, urm;
        logic [4:0] rd;
        logic       mr, br, req, ack;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl [10];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rn, input logic [4:0] rm, input logic urn, input logic urm,
                          input logic [4:0] rd, input logic mr, input logic br,
                          input logic req, input logic ack);
        id_rn = rn; id_rm = rm; id_use_rn = urn; id_use_rm = urm;
        ex_rd = rd; ex_mem_read = mr; ex_branch_taken = br; mem_req = req; mem_ack = ack;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        reset_to = 1'b0;
        idle();

        tbl[0] = '{5'd1,  5'd2,  1'b1, 1'b1, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0, O_NORM};
        tbl[1] = '{5'd3,  5'd2,  1'b1, 1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, O_LUH};
        tbl[2] = '{5'd1,  5'd7,  1'b0, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, O_LUH};
        tbl[3] = '{5'd3,  5'd2,  1'b0, 1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, O_NORM};
        tbl[4] = '{5'd31, 5'd2,  1'b1, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, O_NORM};
        tbl[5] = '{5'd3,  5'd3,  1'b1, 1'b1, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0, O_NORM};
        tbl[6] = '{5'd3,  5'd2,  1'b1, 1'b1, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0, O_BR};
        tbl[7] = '{5'd1,  5'd2,  1'b1, 1'b1, 5'd3,  1'b0, 1'b1, 1'b0, 1'b0, O_BR};
        tbl[8] = '{5'd1,  5'd2,  1'b1, 1'b1, 5'd3,  1'b0, 1'b0, 1'b1, 1'b1, O_NORM};
        tbl[9] = '{5'd4,  5'd9,  1'b1, 1'b0, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, O_NORM};

        // Reset state: outputs held low even with a taken branch on the inputs.
        repeat (2) next_cycle();
        ex_branch_taken = 1'b1;
        #2;
        chk("rst_outs", 32'(outs), 32'(O_OFF));
        chk("rst_stall", stall_count, 0);
        chk("rst_flush", flush_count, 0);
        chk("rst_err", 32'(mem_error), 0);
        chk("rst_outs_to", 32'(outs_t), 32'(O_OFF));
        idle();
        reset = 1'b1;
        next_cycle();

        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].rn, tbl[i].rm, tbl[i].urn, tbl[i].urm, tbl[i].rd,
                   tbl[i].mr, tbl[i].br, tbl[i].req, tbl[i].ack);
            #2;
            chk($sformatf("vec%0d", i), 32'(outs), 32'(tbl[i].exp));
            next_cycle();
        end
        chk("tbl_stall", stall_count, 2);
        chk("tbl_flush", flush_count, 2);

        idle();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        next_cycle();

        // Memory freeze for 5 cycles, released in the ack cycle.
        mem_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #2;
            chk($sformatf("mw_frz%0d", c), 32'(outs), 32'(O_FRZ));
            next_cycle();
        end
        mem_ack = 1'b1;
        #2;
        chk("mw_ack", 32'(outs), 32'(O_NORM));
        next_cycle();
        idle();
        #2;
        chk("mw_after", 32'(outs), 32'(O_NORM));
        chk("mw_stall", stall_count, 5);
        chk("mw_flush", flush_count, 0);

        // Ack cycle coinciding with a taken branch and a load-use pattern.
        next_cycle();
        mem_req = 1'b1;
        #2;
        chk("mwb_frz0", 32'(outs), 32'(O_FRZ));
        next_cycle();
        #2;
        chk("mwb_frz1", 32'(outs), 32'(O_FRZ));
        next_cycle();
        set_in(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1);
        #2;
        chk("mwb_ack_br", 32'(outs), 32'(O_BR));
        next_cycle();
        idle();
        chk("mwb_flush", flush_count, 1);
        chk("mwb_stall", stall_count, 7);

        // Ack cycle with a load-use hazard stalls one more cycle.
        mem_req = 1'b1;
        next_cycle();
        set_in(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        #2;
        chk("mwl_ack_luh", 32'(outs), 32'(O_LUH));
        next_cycle();
        idle();
        chk("mwl_stall", stall_count, 9);

        // Reset asserted mid-freeze.
        next_cycle();
        ex_branch_taken = 1'b1;
        next_cycle();
        chk("mr_flush_pre", flush_count, 2);
        idle();
        mem_req = 1'b1;
        repeat (3) next_cycle();
        #2;
        chk("mr_frz", 32'(outs), 32'(O_FRZ));
        reset = 1'b0;
        #1;
        chk("mr_outs", 32'(outs), 32'(O_OFF));
        chk("mr_stall", stall_count, 0);
        chk("mr_flush", flush_count, 0);
        mem_req = 1'b0;
        reset = 1'b1;
        #1;
        chk("mr_run", 32'(outs), 32'(O_NORM));
        next_cycle();
        chk("mr_stall_post", stall_count, 0);
        chk("mr_flush_post", flush_count, 0);

        // Timeout on the MAX_WAIT=4 instance, then saturation of its 3-bit stall counter.
        idle();
        reset_to = 1'b1;
        next_cycle();
        mem_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #2;
            chk($sformatf("to_frz%0d", c), 32'(outs_t), 32'(O_FRZ));
            chk($sformatf("to_err_lo%0d", c), 32'(mem_error_t), 0);
            next_cycle();
        end
        chk("to_err", 32'(mem_error_t), 1);
        chk("to_stall5", 32'(stall_count_t), 5);
        mem_ack = 1'b1;
        #2;
        chk("to_ack_frz", 32'(outs_t), 32'(O_FRZ));
        next_cycle();
        chk("to_stall6", 32'(stall_count_t), 6);
        chk("to_err_hold", 32'(mem_error_t), 1);
        repeat (3) next_cycle();
        chk("to_stall_sat", 32'(stall_count_t), 7);
        chk("to_frz_hold", 32'(outs_t), 32'(O_FRZ));
        #2;
        reset_to = 1'b0;
        #1;
        chk("to_rst_outs", 32'(outs_t), 32'(O_OFF));
        chk("to_rst_err", 32'(mem_error_t), 0);
        chk("to_rst_stall", 32'(stall_count_t), 0);
        idle();
        reset_to = 1'b1;
        #1;
        chk("to_run", 32'(outs_t), 32'(O_NORM));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
